// File: rtl/window_serializer.sv
// Parallel-in / serial-out window buffer: captures REG_NUM elements in one cycle and
// streams them out one per handshake, allowing a new window to load on the last beat.
module window_serializer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned REG_NUM    = 25,
    parameter int unsigned IDX_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] in_vec [REG_NUM],
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [15:0]           win_cnt
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(REG_NUM - 1);

    state_e                state_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] buf_q [REG_NUM];
    logic [15:0]           win_cnt_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic                  beat;
    logic                  last_beat;
    logic                  load_acc;
    logic [IDX_WIDTH-1:0]  idx_nxt;

    always_comb begin
        beat      = out_valid_q && out_ready;
        last_beat = beat && out_last_q;
        // The last-element beat frees the buffer, so a new window may land in the same cycle.
        load_ready = !flush && ((state_q == StIdle) || last_beat);
        load_acc   = load_valid && load_ready;
        idx_nxt    = idx_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            win_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                buf_q[i] <= '0;
            end
        end else if (flush) begin
            // Abort only: the buffer keeps its contents and the window is not counted.
            state_q     <= StIdle;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (load_acc) begin
            buf_q       <= in_vec;
            state_q     <= StStream;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (REG_NUM == 1);
            out_data_q  <= in_vec[0];
            if (last_beat) begin
                win_cnt_q <= win_cnt_q + 16'd1;
            end
        end else if (beat) begin
            if (out_last_q) begin
                win_cnt_q   <= win_cnt_q + 16'd1;
                state_q     <= StIdle;
                idx_q       <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                idx_q      <= idx_nxt;
                out_data_q <= buf_q[idx_nxt];
                out_last_q <= (idx_nxt == LastIdx);
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_idx   = idx_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign win_cnt   = win_cnt_q;

endmodule

// File: tb/tb_window_serializer.sv
// Bench for window_serializer: window-level reference model checked every cycle, directed
// scenarios with literal expectations, random traffic, and a 1-element instance for wrap.
module tb_window_serializer;

    localparam int DW = 16;
    localparam int RN = 25;
    localparam int IW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, load_valid, out_ready;
    logic [DW-1:0] in_vec [RN];
    logic          load_ready, out_valid, out_last;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic [15:0]   win_cnt;

    window_serializer #(.DATA_WIDTH(DW), .REG_NUM(RN), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .load_valid(load_valid), .load_ready(load_ready),
        .in_vec(in_vec), .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .win_cnt(win_cnt)
    );

    // One-element windows streamed back to back: one completed window per cycle.
    logic          rst_w;
    logic [DW-1:0] wrap_vec [1];
    logic          wrap_lr, wrap_valid, wrap_last;
    logic [DW-1:0] wrap_data;
    logic [0:0]    wrap_idx;
    logic [15:0]   wrap_cnt;

    assign wrap_vec[0] = 16'h1234;

    window_serializer #(.DATA_WIDTH(DW), .REG_NUM(1), .IDX_WIDTH(1)) dut_wrap (
        .clk(clk), .rst(rst_w), .flush(1'b0), .load_valid(1'b1), .load_ready(wrap_lr),
        .in_vec(wrap_vec), .out_data(wrap_data), .out_idx(wrap_idx), .out_valid(wrap_valid),
        .out_ready(1'b1), .out_last(wrap_last), .win_cnt(wrap_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which window is held, which element is on offer, windows completed.
    logic [DW-1:0] m_win [RN];
    int            m_pos = 0;
    bit            m_active = 1'b0;
    logic [15:0]   m_cnt = '0;
    bit            acc_pending = 1'b0;
    int            run_len = 0;
    int            last_run = 0;

    always @(negedge clk) begin
        bit exp_lr;
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_idx", out_idx, 0);
            chk("rst_win_cnt", win_cnt, 0);
            m_active = 1'b0;
            m_pos = 0;
            m_cnt = '0;
            for (int i = 0; i < RN; i++) m_win[i] = '0;
            acc_pending = 1'b0;
            run_len = 0;
        end else begin
            exp_lr = !flush && (!m_active || (m_pos == RN - 1 && out_ready));
            chk("load_ready", load_ready, exp_lr);
            chk("out_valid", out_valid, m_active);
            chk("out_last", out_last, m_active && m_pos == RN - 1);
            if (m_active) begin
                chk("out_data", out_data, m_win[m_pos]);
                chk("out_idx", out_idx, m_pos);
            end
            chk("win_cnt", win_cnt, m_cnt);
            if (out_valid) run_len++;
            else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
            acc_pending = load_valid && exp_lr;
            if (flush) begin
                m_active = 1'b0;
                m_pos = 0;
            end else begin
                if (m_active && out_ready && m_pos == RN - 1) m_cnt++;
                if (acc_pending) begin
                    m_win = in_vec;
                    m_pos = 0;
                    m_active = 1'b1;
                end else if (m_active && out_ready) begin
                    if (m_pos == RN - 1) m_active = 1'b0;
                    else m_pos++;
                end
            end
        end
    end

    // Returns on the rising edge at which the offered window is taken.
    task automatic wait_accept(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_pending && n < 300);
        if (!acc_pending) $display("FAIL %s_timeout: got no accept expected accept", name);
        checks++;
        if (!acc_pending) failures++;
    endtask

    task automatic set_ramp(input logic [15:0] base);
        for (int i = 0; i < RN; i++) in_vec[i] = base + 16'(i);
    endtask

    task automatic set_random();
        for (int i = 0; i < RN; i++) in_vec[i] = 16'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rst_w = 1'b1;
        flush = 1'b0;
        load_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < RN; i++) in_vec[i] = '0;
        fork
            begin : main_seq
                logic [DW-1:0] new0;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("idle_load_ready", load_ready, 1);
                chk("idle_win_cnt", win_cnt, 0);

                // Ramp window with the consumer always ready.
                @(posedge clk); #1;
                out_ready = 1'b1;
                set_ramp(16'h0100);
                load_valid = 1'b1;
                wait_accept("ramp");
                #1 load_valid = 1'b0;
                for (int k = 0; k < RN; k++) begin
                    @(negedge clk);
                    chk("ramp_valid", out_valid, 1);
                    chk("ramp_data", out_data, 16'h0100 + 16'(k));
                    chk("ramp_idx", out_idx, k);
                    chk("ramp_last", out_last, k == RN - 1);
                end
                @(negedge clk);
                chk("ramp_done_valid", out_valid, 0);
                chk("ramp_win_cnt", win_cnt, 1);

                // Same window with a toggling consumer.
                @(posedge clk); #1;
                load_valid = 1'b1;
                wait_accept("toggle");
                #1 load_valid = 1'b0;
                for (int c = 0; c < 70; c++) begin
                    out_ready = (c % 2 == 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                repeat (30) @(posedge clk);
                #1 chk("toggle_win_cnt", win_cnt, 2);

                // Back-to-back windows A then B with load_valid held.
                set_ramp(16'hA000);
                load_valid = 1'b1;
                wait_accept("win_a");
                #1 set_ramp(16'hB000);
                wait_accept("win_b");
                #1 load_valid = 1'b0;
                repeat (30) @(posedge clk);
                #1;
                chk("b2b_run_len", last_run, 50);
                chk("b2b_win_cnt", win_cnt, 4);

                // Flush while element 10 is on offer.
                set_random();
                load_valid = 1'b1;
                wait_accept("flush_win");
                #1 load_valid = 1'b0;
                repeat (10) @(posedge clk);
                #1 flush = 1'b1;
                @(negedge clk);
                chk("flush_idx", out_idx, 10);
                chk("flush_load_ready", load_ready, 0);
                @(posedge clk);
                #1 flush = 1'b0;
                @(negedge clk);
                chk("flush_valid", out_valid, 0);
                chk("flush_win_cnt", win_cnt, 4);
                @(posedge clk); #1;
                set_random();
                new0 = in_vec[0];
                load_valid = 1'b1;
                wait_accept("after_flush");
                #1 load_valid = 1'b0;
                @(negedge clk);
                chk("reload_idx", out_idx, 0);
                chk("reload_data", out_data, new0);
                repeat (30) @(posedge clk);
                #1 chk("reload_win_cnt", win_cnt, 5);

                // Asynchronous reset while element 7 is on offer.
                set_random();
                load_valid = 1'b1;
                wait_accept("rst_win");
                #1 load_valid = 1'b0;
                repeat (7) @(posedge clk);
                #1 rst = 1'b1;
                #1;
                chk("arst_valid", out_valid, 0);
                chk("arst_last", out_last, 0);
                chk("arst_data", out_data, 0);
                chk("arst_idx", out_idx, 0);
                chk("arst_win_cnt", win_cnt, 0);
                @(posedge clk);
                #1 rst = 1'b0;
                set_ramp(16'h0100);
                load_valid = 1'b1;
                wait_accept("post_rst");
                #1 load_valid = 1'b0;
                repeat (30) @(posedge clk);
                #1 chk("post_rst_win_cnt", win_cnt, 1);

                // Random traffic, including loads offered while busy and occasional flushes.
                for (int c = 0; c < 2000; c++) begin
                    set_random();
                    load_valid = ($urandom_range(0, 3) == 0);
                    out_ready = ($urandom_range(0, 3) != 0);
                    flush = ($urandom_range(0, 59) == 0);
                    @(posedge clk); #1;
                end
                load_valid = 1'b0;
                flush = 1'b0;
                out_ready = 1'b1;
                repeat (30) @(posedge clk);
                #1;
            end
            begin : wrap_seq
                repeat (2) @(posedge clk);
                #1 rst_w = 1'b0;
                repeat (2) @(posedge clk);
                #1 chk("wrap_cnt_early", wrap_cnt, 1);
                repeat (65534) @(posedge clk);
                #1 chk("wrap_cnt_max", wrap_cnt, 16'hFFFF);
                @(posedge clk);
                #1 chk("wrap_cnt_zero", wrap_cnt, 16'h0000);
                chk("wrap_valid", wrap_valid, 1);
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
